// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/LSU arbiter for the single core memory port
module mem_port_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req_ip,
    input  logic [31:0] if_addr_ip,
    output logic        if_gnt_op,
    output logic        if_rvalid_op,
    output logic [31:0] if_rdata_op,
    input  logic        lsu_req_ip,
    input  logic        lsu_we_ip,
    input  logic [3:0]  lsu_be_ip,
    input  logic [31:0] lsu_addr_ip,
    input  logic [31:0] lsu_wdata_ip,
    output logic        lsu_gnt_op,
    output logic        lsu_rvalid_op,
    output logic [31:0] lsu_rdata_op,
    output logic        mem_req_op,
    output logic        mem_we_op,
    output logic [3:0]  mem_be_op,
    output logic [31:0] mem_addr_op,
    output logic [31:0] mem_wdata_op,
    input  logic        mem_gnt_ip,
    input  logic        mem_rvalid_ip,
    input  logic [31:0] mem_rdata_ip,
    output logic        timeout_err_op
);

    typedef enum logic [1:0] {S_IDLE, S_REQ_HOLD, S_WAIT_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LSU} owner_t;

    localparam int             CW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TO_MAX     = CW'(TIMEOUT_CYCLES);
    localparam logic [3:0]     STARVE_MAX = 4'(STARVE_LIMIT);

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    owner_t        arb_owner, cur_owner;
    logic [3:0]    starve_q;
    logic          contested_q;
    logic [CW-1:0] to_cnt_q;
    logic          both_req, cur_contested, grant, resp, timeout_hit;

    // Arbitration and per-cycle event decode shared by all processes
    always_comb begin
        both_req = if_req_ip & lsu_req_ip;
        if (if_req_ip && (!lsu_req_ip || starve_q == STARVE_MAX))
            arb_owner = OWN_FETCH;
        else if (lsu_req_ip)
            arb_owner = OWN_LSU;
        else
            arb_owner = OWN_NONE;
        cur_owner     = (state_q == S_IDLE) ? arb_owner : owner_q;
        cur_contested = (state_q == S_IDLE) ? both_req : contested_q;
        grant         = mem_gnt_ip && ((state_q == S_IDLE && arb_owner != OWN_NONE)
                                       || state_q == S_REQ_HOLD);
        resp          = (state_q == S_WAIT_RESP) && mem_rvalid_ip;
        // A response in the timeout cycle wins over the error
        timeout_hit   = (state_q == S_WAIT_RESP) && !mem_rvalid_ip && (to_cnt_q == TO_MAX);
    end

    // State and owner registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            S_IDLE: begin
                if (arb_owner != OWN_NONE) begin
                    owner_d = arb_owner;
                    state_d = mem_gnt_ip ? S_WAIT_RESP : S_REQ_HOLD;
                end
            end
            S_REQ_HOLD: begin
                if (mem_gnt_ip)
                    state_d = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                if (resp || timeout_hit) begin
                    state_d = S_IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // Starvation counter, contention flag and response timeout counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_q    <= 4'd0;
            contested_q <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            if (state_q == S_IDLE)
                contested_q <= both_req;
            if (state_q == S_WAIT_RESP)
                to_cnt_q <= to_cnt_q + 1'b1;
            else
                to_cnt_q <= '0;
            if (grant) begin
                if (cur_owner == OWN_FETCH)
                    starve_q <= 4'd0;
                else if (cur_contested && starve_q != STARVE_MAX)
                    starve_q <= starve_q + 4'd1;
            end
        end
    end

    // Outputs; everything is forced low while reset is asserted
    always_comb begin
        if_gnt_op      = 1'b0;
        if_rvalid_op   = 1'b0;
        if_rdata_op    = 32'd0;
        lsu_gnt_op     = 1'b0;
        lsu_rvalid_op  = 1'b0;
        lsu_rdata_op   = 32'd0;
        mem_req_op     = 1'b0;
        mem_we_op      = 1'b0;
        mem_be_op      = 4'd0;
        mem_addr_op    = 32'd0;
        mem_wdata_op   = 32'd0;
        timeout_err_op = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE, S_REQ_HOLD: begin
                    if (cur_owner == OWN_FETCH) begin
                        mem_req_op  = 1'b1;
                        mem_be_op   = 4'hF;
                        mem_addr_op = if_addr_ip;
                        if_gnt_op   = mem_gnt_ip;
                    end else if (cur_owner == OWN_LSU) begin
                        mem_req_op   = 1'b1;
                        mem_we_op    = lsu_we_ip;
                        mem_be_op    = lsu_be_ip;
                        mem_addr_op  = lsu_addr_ip;
                        mem_wdata_op = lsu_wdata_ip;
                        lsu_gnt_op   = mem_gnt_ip;
                    end
                end
                S_WAIT_RESP: begin
                    if (mem_rvalid_ip) begin
                        if (owner_q == OWN_FETCH) begin
                            if_rvalid_op = 1'b1;
                            if_rdata_op  = mem_rdata_ip;
                        end else if (owner_q == OWN_LSU) begin
                            lsu_rvalid_op = 1'b1;
                            lsu_rdata_op  = mem_rdata_ip;
                        end
                    end
                    timeout_err_op = timeout_hit;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
